burst_ram: RTL
==============

BURST_RAM -- requirements
Module: burst_ram

Interface
REQ-001 Parameter ADDR_W, default 8, address width; memory depth SHALL be 2**ADDR_W words.
REQ-002 Parameter DATA_W, default 8, data word width; ADDR_W SHALL be <= DATA_W.
REQ-003 Parameter AUTO_INC, default 1, 1 enables post-access address increment, 0 disables it.
REQ-004 Parameter RD_LAT, default 1, read latency in cycles; legal values 1 and 2 only.
REQ-005 clk  in  1  single clock, all state updates on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 rx_valid  in  1  din carries a command this cycle.
REQ-008 din  in  DATA_W+2  [DATA_W+1:DATA_W] opcode, [DATA_W-1:0] payload.
REQ-009 tx_ack  in  1  consumer accepts current dout.
REQ-010 ovr_clr  in  1  clears overrun flag.
REQ-011 dout  out  DATA_W  read data, registered.
REQ-012 tx_valid  out  1  dout holds unacknowledged read data.
REQ-013 overrun  out  1  sticky: read data lost before acknowledgement.

Function
REQ-014 A command SHALL be accepted on each rising edge with rx_valid=1; nothing happens when rx_valid=0.
REQ-015 Opcode 00 SHALL load wr_addr <= payload[ADDR_W-1:0].
REQ-016 Opcode 01 SHALL write payload to mem[wr_addr]; with AUTO_INC=1, wr_addr SHALL increment by 1 in the same edge.
REQ-017 Opcode 10 SHALL load rd_addr <= payload[ADDR_W-1:0].
REQ-018 Opcode 11 SHALL launch a read of mem[rd_addr]; with AUTO_INC=1, rd_addr SHALL increment by 1 in the same edge; the payload is ignored.
REQ-019 Address increments SHALL wrap modulo 2**ADDR_W, so address 2**ADDR_W-1 is followed by 0.
REQ-020 Read data for a read accepted at edge E0 SHALL appear on dout with tx_valid=1 after edge E0 (RD_LAT=1) or after edge E0+1 (RD_LAT=2).
REQ-021 Back-to-back reads SHALL be accepted every cycle; the read pipeline SHALL never stall.
REQ-022 A write at edge E0 followed by a read of the same address accepted at edge E0+1 or later SHALL return the new data.
REQ-023 Output handshake states: EMPTY (tx_valid=0), FULL (tx_valid=1).
REQ-024 EMPTY -> FULL when read data completes.
REQ-025 FULL -> EMPTY on an edge with tx_ack=1 and no completing read.
REQ-026 FULL stays FULL while tx_ack=0; dout SHALL hold its value.
REQ-027 When FULL with tx_ack=0 and a read completes, dout SHALL take the new data, tx_valid SHALL stay 1, and overrun SHALL set.
REQ-028 When FULL with tx_ack=1 and a read completes in the same edge, dout SHALL take the new data, tx_valid SHALL stay 1, and overrun SHALL NOT set.
REQ-029 tx_ack while EMPTY SHALL have no effect.
REQ-030 ovr_clr=1 SHALL clear overrun unless a new overrun occurs in the same edge; a new overrun SHALL take priority and leave overrun set.
REQ-031 Write commands SHALL never affect dout, tx_valid or overrun.

Reset
REQ-032 While rst=1: dout=0, tx_valid=0, overrun=0, wr_addr=0, rd_addr=0, all read-pipeline valid bits 0; applied immediately without waiting for a clock edge.
REQ-033 A read in flight when rst asserts SHALL be discarded and SHALL produce no tx_valid after rst deasserts.
REQ-034 Memory contents SHALL NOT be reset.
REQ-035 The first edge after rst deasserts SHALL accept commands normally.

Verification
REQ-036 Write burst: opcode 00 addr 0x10, then opcode 01 data 0xA1, 0xA2, 0xA3 on consecutive cycles; opcode 10 addr 0x10, then three opcode-11 reads with tx_ack=1 -> dout 0xA1, 0xA2, 0xA3 on consecutive cycles, tx_valid high for 3 cycles.
REQ-037 Wrap: write at addr 0xFF then a second write with AUTO_INC=1 -> the second data lands at 0x00; a read burst starting at 0xFF returns both words in order.
REQ-038 Overrun: two reads with tx_ack=0 -> dout shows the second word, overrun=1; pulse ovr_clr -> overrun=0; a read completing with tx_ack=1 -> overrun stays 0.
REQ-039 Latency: RD_LAT=2 build, read accepted at edge E0 -> tx_valid first high after edge E0+1, not after E0.
REQ-040 AUTO_INC=0: two opcode-01 writes 0x11 then 0x22 at addr 5 -> a read of addr 5 returns 0x22, and addr 6 is unchanged.
REQ-041 Reset mid-read: assert rst between read accept and data completion -> tx_valid=0 immediately and stays 0 after release; memory data is still readable afterwards.

Source files
------------

// File: rtl/burst_ram.sv
// burst_ram: command-driven single-port RAM with auto-incrementing burst addresses
// and a registered, acknowledged read-data output.
//
// Ports
//   clk       in   rising-edge clock for all state
//   rst       in   asynchronous active-high reset
//   rx_valid  in   din carries a command this cycle
//   din       in   [DATA_W+1:DATA_W] opcode, [DATA_W-1:0] payload
//                  00 load wr_addr, 01 write, 10 load rd_addr, 11 read
//   tx_ack    in   consumer accepts the current dout
//   ovr_clr   in   clears the sticky overrun flag
//   dout      out  registered read data
//   tx_valid  out  dout holds unacknowledged read data
//   overrun   out  sticky: read data replaced before it was acknowledged
//
// Output handshake states
//   state | meaning
//   EMPTY | no unacknowledged read data (tx_valid=0)
//   FULL  | dout holds read data awaiting tx_ack (tx_valid=1)

module burst_ram #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int AUTO_INC = 1,
    parameter int RD_LAT   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [DATA_W+1:0] din,
    input  logic              tx_ack,
    input  logic              ovr_clr,
    output logic [DATA_W-1:0] dout,
    output logic              tx_valid,
    output logic              overrun
);

    localparam int DEPTH = 1 << ADDR_W;

    generate
        if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
            $error("burst_ram: RD_LAT must be 1 or 2");
        end
        if (ADDR_W > DATA_W) begin : g_bad_width
            $error("burst_ram: ADDR_W must not exceed DATA_W");
        end
    endgenerate

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

    logic [1:0]        opcode;
    logic [DATA_W-1:0] payload;
    logic              do_wr_addr;
    logic              do_write;
    logic              do_rd_addr;
    logic              do_read;

    assign opcode     = din[DATA_W+1:DATA_W];
    assign payload    = din[DATA_W-1:0];
    assign do_wr_addr = rx_valid && (opcode == 2'b00);
    assign do_write   = rx_valid && (opcode == 2'b01);
    assign do_rd_addr = rx_valid && (opcode == 2'b10);
    assign do_read    = rx_valid && (opcode == 2'b11);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;

    // Increments rely on natural ADDR_W-bit wraparound.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_addr <= '0;
            rd_addr <= '0;
        end else begin
            if (do_wr_addr) begin
                wr_addr <= payload[ADDR_W-1:0];
            end else if (do_write && (AUTO_INC != 0)) begin
                wr_addr <= wr_addr + 1'b1;
            end
            if (do_rd_addr) begin
                rd_addr <= payload[ADDR_W-1:0];
            end else if (do_read && (AUTO_INC != 0)) begin
                rd_addr <= rd_addr + 1'b1;
            end
        end
    end

    // Memory contents survive reset on purpose.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_addr] <= payload;
        end
    end

    // cmp_valid/cmp_data: a read completing at this edge.
    logic              cmp_valid;
    logic [DATA_W-1:0] cmp_data;

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              s1_valid;
            logic [DATA_W-1:0] s1_data;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s1_valid <= 1'b0;
                    s1_data  <= '0;
                end else begin
                    s1_valid <= do_read;
                    if (do_read) begin
                        s1_data <= mem[rd_addr];
                    end
                end
            end

            assign cmp_valid = s1_valid;
            assign cmp_data  = s1_data;
        end else begin : g_lat1
            assign cmp_valid = do_read;
            assign cmp_data  = mem[rd_addr];
        end
    endgenerate

    out_state_t state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= EMPTY;
            dout    <= '0;
            overrun <= 1'b0;
        end else begin
            if (cmp_valid) begin
                dout  <= cmp_data;
                state <= FULL;
            end else if ((state == FULL) && tx_ack) begin
                state <= EMPTY;
            end

            // A fresh overrun outranks a simultaneous clear.
            if (cmp_valid && (state == FULL) && !tx_ack) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end
        end
    end

    assign tx_valid = (state == FULL);

endmodule
